// File: rtl/ysyx_23060221_axi_arbiter_pkg.sv
// Shared definitions for the two-requester AXI4 arbiter: state encoding,
// AXI response codes and default bus widths.
package ysyx_23060221_axi_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 64;
  localparam int ID_W_DEF   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD0  = 2'd1,
    ST_RD1  = 2'd2,
    ST_WR1  = 2'd3
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic is_rd_state(input arb_state_e st);
    return (st == ST_RD0) || (st == ST_RD1);
  endfunction

endpackage

// File: rtl/ysyx_23060221_axi_arbiter_if.sv
// Single-beat AXI4 channel bundle. 'master' is the initiator view, 'slave' the
// target view, 'slave_rd' the target view of a read-only initiator (IFU).
interface ysyx_23060221_axi_arbiter_if #(
  parameter int ADDR_W = ysyx_23060221_axi_arbiter_pkg::ADDR_W_DEF,
  parameter int DATA_W = ysyx_23060221_axi_arbiter_pkg::DATA_W_DEF,
  parameter int ID_W   = ysyx_23060221_axi_arbiter_pkg::ID_W_DEF
);

  logic                arvalid;
  logic                arready;
  logic [ADDR_W-1:0]   araddr;
  logic [ID_W-1:0]     arid;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;

  logic                rvalid;
  logic                rready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic [ID_W-1:0]     rid;

  logic                awvalid;
  logic                awready;
  logic [ADDR_W-1:0]   awaddr;
  logic [ID_W-1:0]     awid;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;

  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic                bvalid;
  logic                bready;
  logic [1:0]          bresp;
  logic [ID_W-1:0]     bid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready
  );

  modport slave_rd (
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready
  );

endinterface

// File: rtl/ysyx_23060221_rr_pick2.sv
// Two-way read pick with round-robin tie break. last_rd_q = 1 means M0 wins
// the next contest, 0 means M1 wins; it records the master granted last.
module ysyx_23060221_rr_pick2
  import ysyx_23060221_axi_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic grant_en,
  output logic pick1
);

  logic last_rd_q;
  logic last_rd_d;

  // pick M1 when it is the only requester or when it owns the tie
  always_comb begin
    pick1 = req1 & (~req0 | ~last_rd_q);
  end

  // remember the winner only when a read grant is actually taken
  always_comb begin
    if (grant_en) begin
      last_rd_d = pick1;
    end else begin
      last_rd_d = last_rd_q;
    end
  end

  // tie-break register, M0 favoured out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_rd_q <= 1'b1;
    end else begin
      last_rd_q <= last_rd_d;
    end
  end

endmodule

// File: rtl/ysyx_23060221_axi_arbiter.sv
// Shares one single-beat AXI4 master port between the IFU (M0, reads only) and
// the EXU LSU (M1, reads and writes); responses follow the latched grant.
module ysyx_23060221_axi_arbiter
  import ysyx_23060221_axi_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ID_W   = ID_W_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  ysyx_23060221_axi_arbiter_if.slave_rd   m0,
  ysyx_23060221_axi_arbiter_if.slave      m1,
  ysyx_23060221_axi_arbiter_if.master     s
);

  arb_state_e state_q, state_d;
  logic       ar_done_q, ar_done_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;

  logic rd_pick1_s;
  logic grant_en_s;
  logic rd_active_s;
  logic rd_sel1_s;
  logic wr_active_s;
  logic ar_req_s;
  logic ar_fire_s;
  logic r_last_fire_s;
  logic aw_req_s;
  logic aw_fire_s;
  logic w_req_s;
  logic w_fire_s;
  logic b_fire_s;

  // a pending write always pre-empts reads, so no read grant in that case
  assign grant_en_s = (state_q == ST_IDLE) & ~m1.awvalid & (m0.arvalid | m1.arvalid);

  ysyx_23060221_rr_pick2 u_rr_pick2 (
    .clk      (clk),
    .rst      (rst),
    .req0     (m0.arvalid),
    .req1     (m1.arvalid),
    .grant_en (grant_en_s),
    .pick1    (rd_pick1_s)
  );

  assign rd_active_s   = is_rd_state(state_q);
  assign rd_sel1_s     = (state_q == ST_RD1);
  assign wr_active_s   = (state_q == ST_WR1);
  assign ar_req_s      = rd_active_s & ~ar_done_q & (rd_sel1_s ? m1.arvalid : m0.arvalid);
  assign ar_fire_s     = ar_req_s & s.arready;
  assign r_last_fire_s = rd_active_s & s.rvalid & s.rlast & (rd_sel1_s ? m1.rready : m0.rready);
  assign aw_req_s      = wr_active_s & m1.awvalid & ~aw_done_q;
  assign aw_fire_s     = aw_req_s & s.awready;
  assign w_req_s       = wr_active_s & m1.wvalid & ~w_done_q;
  assign w_fire_s      = w_req_s & s.wready;
  assign b_fire_s      = wr_active_s & s.bvalid & m1.bready;

  // state and handshake-flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // next-state: arbitration in IDLE, completion detection otherwise
  always_comb begin
    state_d   = state_q;
    ar_done_d = ar_done_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      ST_IDLE: begin
        ar_done_d = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (m1.awvalid) begin
          state_d = ST_WR1;
        end else if (rd_pick1_s) begin
          state_d = ST_RD1;
        end else if (m0.arvalid) begin
          state_d = ST_RD0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD0, ST_RD1: begin
        if (r_last_fire_s) begin
          state_d   = ST_IDLE;
          ar_done_d = 1'b0;
        end else begin
          ar_done_d = ar_done_q | ar_fire_s;
        end
      end
      ST_WR1: begin
        if (b_fire_s) begin
          state_d   = ST_IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_fire_s;
          w_done_d  = w_done_q | w_fire_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // channel muxing: only the granted master sees anything but zeros
  always_comb begin
    m0.arready = 1'b0;
    m0.rvalid  = 1'b0;
    m0.rdata   = {DATA_W{1'b0}};
    m0.rresp   = 2'b00;
    m0.rlast   = 1'b0;
    m0.rid     = {ID_W{1'b0}};

    m1.arready = 1'b0;
    m1.rvalid  = 1'b0;
    m1.rdata   = {DATA_W{1'b0}};
    m1.rresp   = 2'b00;
    m1.rlast   = 1'b0;
    m1.rid     = {ID_W{1'b0}};
    m1.awready = 1'b0;
    m1.wready  = 1'b0;
    m1.bvalid  = 1'b0;
    m1.bresp   = 2'b00;
    m1.bid     = {ID_W{1'b0}};

    s.arvalid  = 1'b0;
    s.araddr   = {ADDR_W{1'b0}};
    s.arid     = {ID_W{1'b0}};
    s.arlen    = 8'd0;
    s.arsize   = 3'd0;
    s.arburst  = 2'b00;
    s.rready   = 1'b0;
    s.awvalid  = 1'b0;
    s.awaddr   = {ADDR_W{1'b0}};
    s.awid     = {ID_W{1'b0}};
    s.awlen    = 8'd0;
    s.awsize   = 3'd0;
    s.awburst  = 2'b00;
    s.wvalid   = 1'b0;
    s.wdata    = {DATA_W{1'b0}};
    s.wstrb    = {(DATA_W/8){1'b0}};
    s.wlast    = 1'b0;
    s.bready   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        s.arvalid = 1'b0;
      end
      ST_RD0: begin
        s.arvalid  = ar_req_s;
        s.araddr   = m0.araddr;
        s.arid     = m0.arid;
        s.arlen    = m0.arlen;
        s.arsize   = m0.arsize;
        s.arburst  = m0.arburst;
        m0.arready = s.arready & ~ar_done_q;
        s.rready   = m0.rready;
        m0.rvalid  = s.rvalid;
        m0.rdata   = s.rdata;
        m0.rresp   = s.rresp;
        m0.rlast   = s.rlast;
        m0.rid     = s.rid;
      end
      ST_RD1: begin
        s.arvalid  = ar_req_s;
        s.araddr   = m1.araddr;
        s.arid     = m1.arid;
        s.arlen    = m1.arlen;
        s.arsize   = m1.arsize;
        s.arburst  = m1.arburst;
        m1.arready = s.arready & ~ar_done_q;
        s.rready   = m1.rready;
        m1.rvalid  = s.rvalid;
        m1.rdata   = s.rdata;
        m1.rresp   = s.rresp;
        m1.rlast   = s.rlast;
        m1.rid     = s.rid;
      end
      ST_WR1: begin
        s.awvalid  = aw_req_s;
        s.awaddr   = m1.awaddr;
        s.awid     = m1.awid;
        s.awlen    = m1.awlen;
        s.awsize   = m1.awsize;
        s.awburst  = m1.awburst;
        m1.awready = s.awready & ~aw_done_q;
        s.wvalid   = w_req_s;
        s.wdata    = m1.wdata;
        s.wstrb    = m1.wstrb;
        s.wlast    = m1.wlast;
        m1.wready  = s.wready & ~w_done_q;
        s.bready   = m1.bready;
        m1.bvalid  = s.bvalid;
        m1.bresp   = s.bresp;
        m1.bid     = s.bid;
      end
      default: begin
        s.arvalid = 1'b0;
      end
    endcase
  end

endmodule
